// File: rtl/msg_stream_parser.sv
// msg_stream_parser: splits AXI-Stream packets carrying a 16-bit message count
// followed by length-prefixed messages into one parallel word per message.
// One input lane (byte) is parsed per cycle out of a one-beat buffer. The
// output side has no backpressure and raises at most one strobe per cycle.
module msg_stream_parser #(
  parameter int DATA_BYTES    = 8,
  parameter int MAX_MSG_BYTES = 32,
  parameter int MIN_MSG_BYTES = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       s_tready,
  input  logic                       s_tvalid,
  input  logic                       s_tlast,
  input  logic [8*DATA_BYTES-1:0]    s_tdata,
  input  logic [DATA_BYTES-1:0]      s_tkeep,
  input  logic                       s_tuser,
  output logic                       msg_valid,
  output logic                       msg_error,
  output logic [15:0]                msg_length,
  output logic [8*MAX_MSG_BYTES-1:0] msg_data,
  output logic [15:0]                msg_count
);

  localparam int LANE_W = $clog2(DATA_BYTES);
  localparam int MSG_W  = 8*MAX_MSG_BYTES;

  localparam logic [2:0] CNT_HI  = 3'd0;
  localparam logic [2:0] CNT_LO  = 3'd1;
  localparam logic [2:0] LEN_HI  = 3'd2;
  localparam logic [2:0] LEN_LO  = 3'd3;
  localparam logic [2:0] PAYLOAD = 3'd4;
  localparam logic [2:0] TRAIL   = 3'd5;
  localparam logic [2:0] DRAIN   = 3'd6;

  // Beat buffer
  logic                    buf_valid_reg;
  logic [8*DATA_BYTES-1:0] buf_data_reg;
  logic [DATA_BYTES-1:0]   buf_keep_reg;
  logic                    buf_last_reg;
  logic                    buf_user_reg;
  logic [LANE_W-1:0]       lane_reg;

  // Parser state
  logic [2:0]       state_reg, state_next;
  logic [15:0]      remaining_reg, remaining_next;
  logic [15:0]      len_reg, len_next;
  logic [15:0]      byte_cnt_reg, byte_cnt_next;
  logic [MSG_W-1:0] asm_reg, asm_next;
  logic             trail_err_reg, trail_err_next;
  logic             done_in_beat_reg, done_in_beat_next;
  logic             pend_err_reg, pend_err_next;
  logic [15:0]      pend_len_reg, pend_len_next;

  // Output registers
  logic             msg_valid_reg;
  logic             msg_error_reg;
  logic [15:0]      msg_length_reg;
  logic [MSG_W-1:0] msg_data_reg;
  logic [15:0]      msg_count_reg;

  // Per-cycle decode
  logic        last_lane;
  logic        accept;
  logic        pkt_end;
  logic [7:0]  cur_byte;
  logic        cur_kept;
  logic [7:0]  lane_bytes [DATA_BYTES];
  logic        asm_clear;
  logic        asm_wr;
  logic        msg_done;
  logic        ev_valid;
  logic        ev_err;
  logic        ev_use_asm;
  logic [15:0] ev_len;
  logic [15:0] full_len;
  logic        truncated;
  logic        end_err;
  logic [15:0] end_len;

  assign last_lane = &lane_reg;
  // Ready is gated by reset so nothing is accepted while held in reset.
  assign s_tready  = rst && (!buf_valid_reg || last_lane);
  assign accept    = s_tvalid && s_tready;
  assign pkt_end   = buf_valid_reg && last_lane && buf_last_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_BYTES; gi++) begin : g_lane
      assign lane_bytes[gi] = buf_data_reg[gi*8 +: 8];
    end
    // Byte-wise assembly register update: clear on a fresh message, write the
    // lane currently addressed by byte_cnt while in PAYLOAD.
    for (gi = 0; gi < MAX_MSG_BYTES; gi++) begin : g_asm
      assign asm_next[gi*8 +: 8] = asm_clear ? 8'd0 :
                                   (asm_wr && byte_cnt_reg == 16'(gi)) ? cur_byte :
                                   asm_reg[gi*8 +: 8];
    end
  endgenerate

  assign cur_byte = lane_bytes[lane_reg];
  assign cur_kept = buf_keep_reg[lane_reg];

  // Parser next-state, emission and end-of-packet error decision for this lane
  always_comb begin
    state_next        = state_reg;
    remaining_next    = remaining_reg;
    len_next          = len_reg;
    byte_cnt_next     = byte_cnt_reg;
    trail_err_next    = trail_err_reg;
    done_in_beat_next = done_in_beat_reg;
    pend_err_next     = 1'b0;
    pend_len_next     = pend_len_reg;
    asm_clear         = 1'b0;
    asm_wr            = 1'b0;
    msg_done          = 1'b0;
    ev_valid          = 1'b0;
    ev_err            = 1'b0;
    ev_use_asm        = 1'b0;
    ev_len            = 16'd0;
    full_len          = {len_reg[15:8], cur_byte};
    truncated         = 1'b0;
    end_err           = 1'b0;
    end_len           = 16'd0;

    // A deferred end-of-packet error goes out now; the lane processed in this
    // cycle is the first of a new packet and cannot produce a strobe itself.
    if (pend_err_reg) begin
      ev_err = 1'b1;
      ev_len = pend_len_reg;
    end

    if (buf_valid_reg && cur_kept) begin
      case (state_reg)
        CNT_HI: begin
          remaining_next[15:8] = cur_byte;
          state_next           = CNT_LO;
        end
        CNT_LO: begin
          remaining_next = {remaining_reg[15:8], cur_byte};
          state_next     = ({remaining_reg[15:8], cur_byte} == 16'd0) ? TRAIL : LEN_HI;
        end
        LEN_HI: begin
          len_next[15:8] = cur_byte;
          state_next     = LEN_LO;
        end
        LEN_LO: begin
          len_next = full_len;
          if (full_len < 16'(MIN_MSG_BYTES) || full_len > 16'(MAX_MSG_BYTES)) begin
            ev_err     = 1'b1;
            ev_len     = full_len;
            state_next = DRAIN;
          end else begin
            asm_clear     = 1'b1;
            byte_cnt_next = 16'd0;
            state_next    = PAYLOAD;
          end
        end
        PAYLOAD: begin
          asm_wr        = 1'b1;
          byte_cnt_next = byte_cnt_reg + 16'd1;
          if (byte_cnt_reg == len_reg - 16'd1) begin
            msg_done       = 1'b1;
            remaining_next = remaining_reg - 16'd1;
            state_next     = (remaining_reg != 16'd1) ? LEN_HI : TRAIL;
          end
        end
        TRAIL: begin
          trail_err_next = 1'b1;
          state_next     = DRAIN;
        end
        default: begin
          state_next = state_reg;
        end
      endcase
    end

    // A message finishing inside an errored tlast beat is reported as an error.
    if (msg_done) begin
      if (buf_last_reg && buf_user_reg) begin
        ev_err            = 1'b1;
        done_in_beat_next = 1'b1;
      end else begin
        ev_valid = 1'b1;
      end
      ev_len     = len_reg;
      ev_use_asm = 1'b1;
    end

    if (pkt_end) begin
      truncated = state_next inside {CNT_HI, CNT_LO, LEN_HI, LEN_LO, PAYLOAD};
      end_len   = (state_next == PAYLOAD) ? len_next : 16'd0;
      end_err   = truncated || trail_err_next || (buf_user_reg && !done_in_beat_next);
      if (end_err) begin
        if (ev_valid) begin
          // Good message on the final lane: report the packet error next cycle.
          pend_err_next = 1'b1;
          pend_len_next = end_len;
        end else if (!ev_err) begin
          ev_err = 1'b1;
          ev_len = end_len;
        end
      end
      state_next        = CNT_HI;
      trail_err_next    = 1'b0;
      done_in_beat_next = 1'b0;
    end
  end

  // Beat buffer: load on handshake, then walk the lanes one per cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid_reg <= 1'b0;
      buf_data_reg  <= '0;
      buf_keep_reg  <= '0;
      buf_last_reg  <= 1'b0;
      buf_user_reg  <= 1'b0;
      lane_reg      <= '0;
    end else if (accept) begin
      buf_valid_reg <= 1'b1;
      buf_data_reg  <= s_tdata;
      buf_keep_reg  <= s_tkeep;
      buf_last_reg  <= s_tlast;
      buf_user_reg  <= s_tuser;
      lane_reg      <= '0;
    end else if (buf_valid_reg) begin
      if (last_lane) begin
        buf_valid_reg <= 1'b0;
      end else begin
        lane_reg <= lane_reg + 1'b1;
      end
    end
  end

  // Parser state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= CNT_HI;
      remaining_reg    <= '0;
      len_reg          <= '0;
      byte_cnt_reg     <= '0;
      asm_reg          <= '0;
      trail_err_reg    <= 1'b0;
      done_in_beat_reg <= 1'b0;
      pend_err_reg     <= 1'b0;
      pend_len_reg     <= '0;
    end else begin
      state_reg        <= state_next;
      remaining_reg    <= remaining_next;
      len_reg          <= len_next;
      byte_cnt_reg     <= byte_cnt_next;
      asm_reg          <= asm_next;
      trail_err_reg    <= trail_err_next;
      done_in_beat_reg <= done_in_beat_next;
      pend_err_reg     <= pend_err_next;
      pend_len_reg     <= pend_len_next;
    end
  end

  // Registered outputs: strobes for one cycle, payload/length held until next event
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msg_valid_reg  <= 1'b0;
      msg_error_reg  <= 1'b0;
      msg_length_reg <= '0;
      msg_data_reg   <= '0;
      msg_count_reg  <= '0;
    end else begin
      msg_valid_reg <= ev_valid;
      msg_error_reg <= ev_err;
      if (ev_valid || ev_err) begin
        msg_length_reg <= ev_len;
        msg_data_reg   <= ev_use_asm ? asm_next : '0;
      end
      if (ev_valid && msg_count_reg != 16'hFFFF) begin
        msg_count_reg <= msg_count_reg + 16'd1;
      end
    end
  end

  assign msg_valid  = msg_valid_reg;
  assign msg_error  = msg_error_reg;
  assign msg_length = msg_length_reg;
  assign msg_data   = msg_data_reg;
  assign msg_count  = msg_count_reg;

endmodule

// File: doc/msg_stream_parser.md
Name: msg_stream_parser

Overview:
- Parametrised successor to the single-message AXI-Stream message parser.
- Accepts AXI-Stream packets of configurable bus width, each carrying a 16-bit message count followed by length-prefixed messages.
- Extracts every message and emits it as one parallel word with a one-cycle strobe, with length/framing/upstream error detection.
- Sits between the packet ingress stream and the message-consumer logic; the output has no backpressure.

Parameters:
DATA_BYTES, 8, input bus width in bytes (power of 2, >=2)
MAX_MSG_BYTES, 32, largest legal payload length, also msg_data width in bytes
MIN_MSG_BYTES, 8, smallest legal payload length (1..MAX_MSG_BYTES)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
s_tready  out  1  slave ready
s_tvalid  in  1  slave valid
s_tlast  in  1  last beat of packet
s_tdata  in  8*DATA_BYTES  beat data, lane 0 = first byte on [7:0]
s_tkeep  in  DATA_BYTES  byte enables, contiguous from lane 0; zeros only on the tlast beat
s_tuser  in  1  upstream error, sampled with tlast
msg_valid  out  1  one-cycle strobe, good message
msg_error  out  1  one-cycle strobe, bad message or packet
msg_length  out  16  payload length of the emitted or errored message
msg_data  out  8*MAX_MSG_BYTES  payload; first byte on [7:0], bytes beyond msg_length are zero
msg_count  out  16  good messages emitted since reset, saturating at 0xFFFF

Behaviour:
- Reset (rst=0, async): all outputs 0; s_tready=1 after reset release; FSM=CNT_HI; beat buffer empty; all counters 0.
- Wire format (big-endian fields): count[15:8], count[7:0], then per message len[15:8], len[7:0], followed by len payload bytes.
- Beat buffer:
  - A beat is accepted on s_tvalid&&s_tready into a one-beat register with keep, last and user.
  - One lane is processed per cycle, lanes 0..DATA_BYTES-1 in order. Lanes with keep=0 consume their cycle but do not advance the parser.
  - s_tready = buffer empty OR the last lane is being processed this cycle. This gives sustained 1 byte/cycle with no bubbles.
- FSM, advancing only on kept bytes:
  - CNT_HI -> CNT_LO -> (count==0 ? TRAIL : LEN_HI).
  - LEN_HI -> LEN_LO. At LEN_LO, length is checked: if len<MIN_MSG_BYTES or len>MAX_MSG_BYTES, pulse msg_error with msg_length=len and msg_data=0, then go to DRAIN. Otherwise clear the data assembly register and go to PAYLOAD.
  - PAYLOAD: write the byte at index byte_cnt. On the final byte, schedule emission and decrement remaining; go to LEN_HI if remaining>0, else TRAIL.
  - TRAIL: any kept byte is a framing error, go to DRAIN.
  - DRAIN: discard bytes until the tlast beat completes.
- Every packet end (last lane of the tlast beat) returns the FSM to CNT_HI.
- Emission:
  - Outputs are registered; msg_valid/msg_error rise the cycle after the lane that completed the message.
  - msg_data/msg_length hold until the next emission. msg_count increments with msg_valid.
- End-of-packet errors, evaluated at the last lane of the tlast beat:
  - tlast in CNT_*, LEN_* or PAYLOAD (truncated packet): pulse msg_error, with msg_length=declared len in PAYLOAD and 0 otherwise.
  - Extra kept bytes were seen in TRAIL: one msg_error pulse.
  - s_tuser=1: a message completing in this beat is emitted with msg_error=1, msg_valid=0. If none completes in the beat, a lone msg_error pulse is emitted. Messages emitted from earlier beats stand.
  - At most one strobe per cycle. If a length error and packet end coincide, report a single msg_error.
- msg_valid and msg_error are never high together.
- Reset mid-packet: abandon all state; no strobe is issued for the partial message.

Test Plan:
1. DATA_BYTES=8: count=2, msg A len 8 (0x01..0x08), msg B len 12 (0x11..0x1C); 26 bytes over 4 beats, last keep=0x03, s_tvalid held high -> two msg_valid pulses, lengths 8 then 12. A data[63:0]=0x0807060504030201, upper bits 0. msg_count=2. s_tready low for no more than 0 cycles between beats.
2. count=1, len=40 (>MAX 32) -> single msg_error with msg_length=40, remaining bytes dropped. The next packet (count=1, len=8) parses normally with msg_valid.
3. count=2, tlast asserted mid-payload of the second message (len 10, 4 bytes received) -> first message msg_valid, then one msg_error with msg_length=10. FSM back at CNT_HI.
4. count=1, len=8, s_tuser=1 on the tlast beat containing the final payload byte -> msg_error=1, msg_valid=0, msg_length=8, msg_count unchanged.
5. Random s_tvalid gaps plus count=0 packets with 2 trailing pad bytes -> no msg_valid, one msg_error per padded packet. count=0 exact packets produce no strobe.
6. Assert rst low mid-PAYLOAD for 1 cycle -> all outputs 0 immediately, msg_count=0. The next full packet is parsed correctly.
